// File: rtl/seven_seg_ext_n.sv
// Registered active-low seven-segment decoder for one common-anode digit.
// A 7-bit command word (blank, dash, lamp test, hex nibble) drives segs_n and dp_n one clock later.
module seven_seg_ext_n (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] data,
   output logic [6:0] segs_n,
   output logic       dp_n
);

   // Free-running: no valid/ready handshake and no enable; every rising edge loads a new word.
   localparam logic [6:0] SEGS_DARK = 7'h7F;
   localparam logic [6:0] SEGS_DASH = 7'h3F;
   localparam logic [6:0] SEGS_ALL  = 7'h00;

   logic [6:0] segs_n_d;
   logic [6:0] segs_n_q;
   logic       dp_n_d;
   logic       dp_n_q;
   logic [6:0] glyph_n;

   // Segment order {g,f,e,d,c,b,a}; a cleared bit lights that segment.
   always_comb begin
      glyph_n = SEGS_DARK;
      case (data[3:0])
         4'h0: glyph_n = 7'h40;
         4'h1: glyph_n = 7'h79;
         4'h2: glyph_n = 7'h24;
         4'h3: glyph_n = 7'h30;
         4'h4: glyph_n = 7'h19;
         4'h5: glyph_n = 7'h12;
         4'h6: glyph_n = 7'h02;
         4'h7: glyph_n = 7'h78;
         4'h8: glyph_n = 7'h00;
         4'h9: glyph_n = 7'h10;
         4'hA: glyph_n = 7'h08;
         4'hB: glyph_n = 7'h03;
         4'hC: glyph_n = 7'h46;
         4'hD: glyph_n = 7'h21;
         4'hE: glyph_n = 7'h06;
         4'hF: glyph_n = 7'h0E;
         default: glyph_n = SEGS_DARK;
      endcase
   end

   // Priority blank > dash > lamp test > digit; lower bits are never looked at once a flag wins.
   always_comb begin
      segs_n_d = SEGS_DARK;
      dp_n_d   = 1'b1;
      if (data[6]) begin
         segs_n_d = SEGS_DARK;
         dp_n_d   = 1'b1;
      end else if (data[5]) begin
         segs_n_d = SEGS_DASH;
         dp_n_d   = 1'b1;
      end else if (data[4]) begin
         segs_n_d = SEGS_ALL;
         dp_n_d   = 1'b0;
      end else begin
         segs_n_d = glyph_n;
         dp_n_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         segs_n_q <= SEGS_DARK;
         dp_n_q   <= 1'b1;
      end else begin
         segs_n_q <= segs_n_d;
         dp_n_q   <= dp_n_d;
      end
   end

   assign segs_n = segs_n_q;
   assign dp_n   = dp_n_q;

endmodule

// File: tb/tb_seven_seg_ext_n.sv
// Directed bench for seven_seg_ext_n: reset, flag priority, glyphs, full sweep, latency and hold.
module tb_seven_seg_ext_n;

   logic       clk;
   logic       rst;
   logic [6:0] data;
   logic [6:0] segs_n;
   logic       dp_n;

   int n_checks;
   int n_fail;

   logic [6:0] glyph_tbl [16];

   seven_seg_ext_n dut (
      .clk    (clk),
      .rst    (rst),
      .data   (data),
      .segs_n (segs_n),
      .dp_n   (dp_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one word at the falling edge, then sample just after the next rising edge.
   task automatic drive_word(input logic [6:0] w);
      @(negedge clk);
      data = w;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      data = 7'h08;
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_immediate: got segs_n=%h dp_n=%b, want 7f/1", segs_n, dp_n);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_held[%0d]: got segs_n=%h dp_n=%b, want 7f/1", i, segs_n, dp_n);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_before_edge: got segs_n=%h dp_n=%b, want 7f/1", segs_n, dp_n);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (segs_n !== 7'h00 || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_load: got segs_n=%h dp_n=%b, want 00/1", segs_n, dp_n);
      end
   endtask

   task automatic test_priority();
      drive_word(7'b1xxxxxx);
      n_checks++;
      if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_blank: got segs_n=%h dp_n=%b, want 7f/1", segs_n, dp_n);
      end
      drive_word(7'b01xxxxx);
      n_checks++;
      if (segs_n !== 7'h3F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_dash: got segs_n=%h dp_n=%b, want 3f/1", segs_n, dp_n);
      end
      drive_word(7'b001xxxx);
      n_checks++;
      if (segs_n !== 7'h00 || dp_n !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_lamp: got segs_n=%h dp_n=%b, want 00/0", segs_n, dp_n);
      end
      // All three flags together, then release lamp test back to the digit.
      drive_word(7'h77);
      n_checks++;
      if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_all_flags: got segs_n=%h dp_n=%b, want 7f/1", segs_n, dp_n);
      end
      drive_word(7'h37);
      n_checks++;
      if (segs_n !== 7'h3F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_dash_lamp: got segs_n=%h dp_n=%b, want 3f/1", segs_n, dp_n);
      end
      drive_word(7'h17);
      n_checks++;
      if (segs_n !== 7'h00 || dp_n !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_lamp_digit: got segs_n=%h dp_n=%b, want 00/0", segs_n, dp_n);
      end
      drive_word(7'h07);
      n_checks++;
      if (segs_n !== 7'h78 || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_release: got segs_n=%h dp_n=%b, want 78/1", segs_n, dp_n);
      end
   endtask

   task automatic test_hex_digits();
      logic [3:0] nib   [3];
      logic [6:0] want  [3];
      nib[0] = 4'hF; want[0] = 7'h0E;
      nib[1] = 4'hC; want[1] = 7'h46;
      nib[2] = 4'hA; want[2] = 7'h08;
      for (int i = 0; i < 3; i++) begin
         drive_word({3'b000, nib[i]});
         n_checks++;
         if (segs_n !== want[i] || dp_n !== 1'b1) begin
            n_fail++;
            $display("FAIL hex_%h: got segs_n=%h dp_n=%b, want %h/1", nib[i], segs_n, dp_n, want[i]);
         end
      end
   endtask

   task automatic test_full_sweep();
      logic [6:0] exp_q [$];
      logic       exp_dp_q [$];
      logic [6:0] w;
      logic [6:0] e_seg;
      logic       e_dp;
      for (int i = 0; i < 16; i++) begin
         w = 7'(i);
         drive_word(w);
         n_checks++;
         if (segs_n !== glyph_tbl[i] || dp_n !== 1'b1) begin
            n_fail++;
            $display("FAIL glyph_%0h: got segs_n=%h dp_n=%b, want %h/1", i, segs_n, dp_n, glyph_tbl[i]);
         end
      end
      for (int i = 0; i < 128; i++) begin
         w = 7'(i);
         if (w[6])      begin e_seg = 7'h7F; e_dp = 1'b1; end
         else if (w[5]) begin e_seg = 7'h3F; e_dp = 1'b1; end
         else if (w[4]) begin e_seg = 7'h00; e_dp = 1'b0; end
         else           begin e_seg = glyph_tbl[w[3:0]]; e_dp = 1'b1; end
         exp_q.push_back(e_seg);
         exp_dp_q.push_back(e_dp);
         drive_word(w);
         e_seg = exp_q.pop_front();
         e_dp  = exp_dp_q.pop_front();
         n_checks++;
         if (segs_n !== e_seg || dp_n !== e_dp) begin
            n_fail++;
            $display("FAIL sweep_%h: got segs_n=%h dp_n=%b, want %h/%b", w, segs_n, dp_n, e_seg, e_dp);
         end
      end
   endtask

   task automatic test_latency_hold();
      drive_word(7'h03);
      n_checks++;
      if (segs_n !== 7'h30 || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_load3: got segs_n=%h dp_n=%b, want 30/1", segs_n, dp_n);
      end
      @(negedge clk);
      data = 7'h08;
      #3;
      data = 7'h40;
      #1;
      n_checks++;
      if (segs_n !== 7'h30 || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_between_edges: got segs_n=%h dp_n=%b, want 30/1", segs_n, dp_n);
      end
      data = 7'h08;
      @(posedge clk);
      #1;
      n_checks++;
      if (segs_n !== 7'h00 || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_next_edge: got segs_n=%h dp_n=%b, want 00/1", segs_n, dp_n);
      end
      drive_word(7'h03);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL midcycle_reset: got segs_n=%h dp_n=%b, want 7f/1", segs_n, dp_n);
      end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL midcycle_reset_release: got segs_n=%h dp_n=%b, want 7f/1", segs_n, dp_n);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (segs_n !== 7'h30 || dp_n !== 1'b1) begin
         n_fail++;
         $display("FAIL midcycle_reset_return: got segs_n=%h dp_n=%b, want 30/1", segs_n, dp_n);
      end
   endtask

   initial begin
      glyph_tbl[0]  = 7'h40; glyph_tbl[1]  = 7'h79; glyph_tbl[2]  = 7'h24; glyph_tbl[3]  = 7'h30;
      glyph_tbl[4]  = 7'h19; glyph_tbl[5]  = 7'h12; glyph_tbl[6]  = 7'h02; glyph_tbl[7]  = 7'h78;
      glyph_tbl[8]  = 7'h00; glyph_tbl[9]  = 7'h10; glyph_tbl[10] = 7'h08; glyph_tbl[11] = 7'h03;
      glyph_tbl[12] = 7'h46; glyph_tbl[13] = 7'h21; glyph_tbl[14] = 7'h06; glyph_tbl[15] = 7'h0E;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      data     = 7'h00;

      test_reset();
      test_priority();
      test_hex_digits();
      test_full_sweep();
      test_latency_hold();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_seg_ext_n.md
# seven_seg_ext_n

Registered, active-low, extended seven-segment decoder for one common-anode digit. It converts a 7-bit command word into segment and decimal-point drive. The word is a hex nibble plus three override flags: blank, dash and lamp test. It sits between display-control logic and the board's segment pins, and its outputs are flopped so the pins are glitch-free.

## Interface
- No parameters.
- clk  input  1  rising-edge clock for the output registers.
- rst  input  1  asynchronous, active-high reset.
- data  input  7  command word:
  - [6] blank
  - [5] dash
  - [4] lamp test
  - [3:0] hex digit
- segs_n  output  7  segment drive, active-low; bit order {g,f,e,d,c,b,a} (bit 0 = a).
- dp_n  output  1  decimal-point drive, active-low.

## Operation
- The next-state value is a fixed priority decode of data. Only the highest-priority asserted flag matters; all lower bits, including X/Z, are don't-care.
  - data[6]=1 (blank): segs_n=7'h7F, dp_n=1.
  - else data[5]=1 (dash): segs_n=7'h3F (segment g only), dp_n=1.
  - else data[4]=1 (lamp test): segs_n=7'h00, dp_n=0 (shows "8.").
  - else: hex glyph of data[3:0], dp_n=1.
- Hex glyphs (segs_n, active-low):
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
- Letters b and d are lower-case; A, C, E and F are upper-case.
- The decode is pure combinational logic feeding an 8-bit output register (segs_n, dp_n). There is no other state.
- No default or illegal cases exist: all 128 input codes map to a defined output.

## Timing
- Reset:
  - While rst=1, segs_n=7'h7F and dp_n=1 (digit dark), independent of clk.
  - Reset assertion takes effect immediately, including mid-cycle.
  - On deassertion, the first rising clk edge loads the decode of the current data.
- Latency is exactly 1 clock: data sampled at edge N appears on the outputs after edge N and holds until edge N+1.
- Outputs change only on a rising clk edge or on rst assertion. Input changes between edges have no effect.
- Flag changes take effect at the next edge:
  - Several flags changing together at one edge resolve by priority (blank > dash > lamp test > digit).
  - Releasing a flag returns the display to the glyph of data[3:0] at the next edge.
- There is no handshake or enable; a new word can be presented every cycle.

## Test plan
- Reset: assert rst with data=7'h08 and clock running -> segs_n=7F, dp_n=1 immediately and while held. Deassert -> after the next edge segs_n=00, dp_n=1.
- Priority, one word per cycle, data[3:0] left X:
  - data[6]=1 -> 7F/1.
  - then data[6:5]=01 -> 3F/1.
  - then data[6:4]=001 -> 00/0.
  - Each result appears one edge after its word is applied.
- Hex digits, flags 0, one per cycle:
  - data[3:0]=F -> 0E.
  - C -> 46.
  - A -> 08.
  - dp_n=1 throughout.
- Full sweep: all 16 nibbles with flags 0 -> outputs match the glyph table exactly, one cycle late. Then all 128 codes against a priority reference model.
- Latency and hold:
  - Change data between edges -> outputs unchanged until the next rising edge.
  - Pulse rst mid-cycle while displaying 3 (30) -> outputs go to 7F at once, then return to 30 one edge after release.
